// File: rtl/pair_diff_detector.sv
// pair_diff_detector
// Consumes the far/near taps of the 7-deep pixel shift register, thresholds
// |p_near - p_far|, reports one feature pulse per qualifying run of
// above-threshold samples and a per-line feature count on line close.
// Optional feature macro: PAIR_DIFF_DIR_EN adds the 'dir' output and makes a
// run continue only while the sign of the difference is unchanged.
module pair_diff_detector #(
    parameter int DW      = 8,
    parameter int PRIME   = 8,
    parameter int MIN_RUN = 3,
    parameter int CW      = 10,
    parameter int FCW     = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           line_start,
    input  logic           line_end,
    input  logic [DW-1:0]  thresh,
    input  logic [DW-1:0]  p_far,
    input  logic [DW-1:0]  p_near,
    output logic           out_valid,
    output logic [DW-1:0]  diff,
    output logic           above,
    output logic           feat,
    output logic [CW-1:0]  feat_col,
    output logic           line_done,
    output logic [FCW-1:0] line_feat_cnt
`ifdef PAIR_DIFF_DIR_EN
    ,
    output logic           dir
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Index of the last discarded sample; 0 means the start sample alone primes.
    localparam logic [7:0]     PRIME_LAST = 8'(PRIME - 1);
    localparam logic [3:0]     MIN_RUN_C  = 4'(MIN_RUN);
    localparam logic [3:0]     MIN_RUN_M1 = 4'(MIN_RUN - 1);
    localparam logic [CW-1:0]  COL_MAX    = {CW{1'b1}};
    localparam logic [FCW-1:0] FCNT_MAX   = {FCW{1'b1}};
    localparam logic [CW-1:0]  COL_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0] FCNT_ONE   = {{(FCW-1){1'b0}}, 1'b1};

    // Magnitude of a - b, formed one bit wider so the sign is never lost.
    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DW]) begin
            d = (~d) + {{DW{1'b0}}, 1'b1};
        end else begin
            d = d;
        end
        return d[DW-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [7:0]     prime_cnt_q, prime_cnt_d;
    logic [CW-1:0]  col_q, col_d;
    logic [3:0]     run_q, run_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  diff_q, diff_d;
    logic           above_q, above_d;
    logic           feat_q, feat_d;
    logic [CW-1:0]  feat_col_q, feat_col_d;
    logic           line_done_q, line_done_d;
    logic [FCW-1:0] line_feat_cnt_q, line_feat_cnt_d;

    logic           start_s, close_s, accept_s, above_s, restart_s, feat_s;
    logic [DW-1:0]  diff_s;
    logic [3:0]     base_s;
    logic [FCW-1:0] fcnt_inc_s;

`ifdef PAIR_DIFF_DIR_EN
    logic           dir_s;
    logic           run_dir_q, run_dir_d;
    logic           dir_q, dir_d;
`endif

    // Per-sample datapath: difference, threshold, run qualification, feature count.
    always_comb begin
        start_s  = in_valid & line_start;
        close_s  = line_end & (state_q != ST_IDLE);
        accept_s = in_valid & ~line_start & (state_q == ST_RUN);
        diff_s   = abs_diff(p_near, p_far);
        above_s  = (diff_s > thresh);
`ifdef PAIR_DIFF_DIR_EN
        dir_s = (p_near > p_far);
        // An above sample against the current run's direction begins a new run.
        if (above_s && (run_q != 4'd0) && (dir_s != run_dir_q)) begin
            restart_s = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
`else
        restart_s = 1'b0;
`endif
        base_s = restart_s ? 4'd0 : run_q;
        feat_s = accept_s & above_s & (base_s == MIN_RUN_M1);
        if (feat_s && (fcnt_q != FCNT_MAX)) begin
            fcnt_inc_s = fcnt_q + FCNT_ONE;
        end else begin
            fcnt_inc_s = fcnt_q;
        end
    end

    // Line state machine plus prime, column, run and feature counters.
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        col_d       = col_q;
        run_d       = run_q;
        fcnt_d      = fcnt_inc_s;
`ifdef PAIR_DIFF_DIR_EN
        run_dir_d   = run_dir_q;
`endif
        if (start_s) begin
            // A start sample always opens a fresh line, whatever state we are in.
            state_d     = (PRIME_LAST == 8'd0) ? ST_RUN : ST_PRIME;
            prime_cnt_d = 8'd1;
            col_d       = {CW{1'b0}};
            run_d       = 4'd0;
            fcnt_d      = {FCW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PRIME: begin
                    if (close_s) begin
                        state_d = ST_IDLE;
                    end else if (in_valid) begin
                        if (prime_cnt_q == PRIME_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            prime_cnt_d = prime_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (col_q != COL_MAX) begin
                            col_d = col_q + COL_ONE;
                        end else begin
                            col_d = col_q;
                        end
                        if (above_s) begin
                            run_d = (base_s < MIN_RUN_C) ? (base_s + 4'd1) : base_s;
`ifdef PAIR_DIFF_DIR_EN
                            run_dir_d = dir_s;
`endif
                        end else begin
                            run_d = 4'd0;
                        end
                    end else begin
                        run_d = run_q;
                    end
                    if (close_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        out_valid_d = accept_s;
        diff_d      = accept_s ? diff_s : diff_q;
        above_d     = accept_s & above_s;
        feat_d      = feat_s;
        feat_col_d  = feat_s ? col_q : {CW{1'b0}};
        line_done_d = close_s;
        if (close_s) begin
            // Includes a feature completed by a sample accepted this same cycle.
            line_feat_cnt_d = fcnt_inc_s;
        end else begin
            line_feat_cnt_d = line_feat_cnt_q;
        end
`ifdef PAIR_DIFF_DIR_EN
        dir_d = accept_s & dir_s;
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            prime_cnt_q     <= 8'd0;
            col_q           <= {CW{1'b0}};
            run_q           <= 4'd0;
            fcnt_q          <= {FCW{1'b0}};
            out_valid_q     <= 1'b0;
            diff_q          <= {DW{1'b0}};
            above_q         <= 1'b0;
            feat_q          <= 1'b0;
            feat_col_q      <= {CW{1'b0}};
            line_done_q     <= 1'b0;
            line_feat_cnt_q <= {FCW{1'b0}};
`ifdef PAIR_DIFF_DIR_EN
            run_dir_q       <= 1'b0;
            dir_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            prime_cnt_q     <= prime_cnt_d;
            col_q           <= col_d;
            run_q           <= run_d;
            fcnt_q          <= fcnt_d;
            out_valid_q     <= out_valid_d;
            diff_q          <= diff_d;
            above_q         <= above_d;
            feat_q          <= feat_d;
            feat_col_q      <= feat_col_d;
            line_done_q     <= line_done_d;
            line_feat_cnt_q <= line_feat_cnt_d;
`ifdef PAIR_DIFF_DIR_EN
            run_dir_q       <= run_dir_d;
            dir_q           <= dir_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign diff          = diff_q;
    assign above         = above_q;
    assign feat          = feat_q;
    assign feat_col      = feat_col_q;
    assign line_done     = line_done_q;
    assign line_feat_cnt = line_feat_cnt_q;
`ifdef PAIR_DIFF_DIR_EN
    assign dir           = dir_q;
`endif

endmodule

// File: tb/tb_pair_diff_detector.sv
// Self-checking bench for pair_diff_detector (PRIME=8, MIN_RUN=3, FCW=2).
// A line-level model predicts every output each cycle; literal expectations
// pin the feature columns and line counts of each directed scenario.
module tb_pair_diff_detector;

    localparam int DW      = 8;
    localparam int PRIME   = 8;
    localparam int MIN_RUN = 3;
    localparam int CW      = 10;
    localparam int FCW     = 2;
    localparam int FCNT_MAX = (1 << FCW) - 1;
    localparam int COL_MAX  = (1 << CW) - 1;
`ifdef PAIR_DIFF_DIR_EN
    localparam bit DIR_ON       = 1'b1;
    localparam int DIR_FEAT_COL = 4;
`else
    localparam bit DIR_ON       = 1'b0;
    localparam int DIR_FEAT_COL = 2;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           line_start = 1'b0;
    logic           line_end = 1'b0;
    logic [DW-1:0]  thresh = '0;
    logic [DW-1:0]  p_far = '0;
    logic [DW-1:0]  p_near = '0;
    logic           dut_ov, dut_above, dut_feat, dut_done;
    logic [DW-1:0]  dut_diff;
    logic [CW-1:0]  dut_col;
    logic [FCW-1:0] dut_lcnt;
`ifdef PAIR_DIFF_DIR_EN
    logic           dut_dir;
`endif

    pair_diff_detector #(
        .DW(DW), .PRIME(PRIME), .MIN_RUN(MIN_RUN), .CW(CW), .FCW(FCW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .line_start(line_start),
        .line_end(line_end), .thresh(thresh), .p_far(p_far), .p_near(p_near),
        .out_valid(dut_ov), .diff(dut_diff), .above(dut_above), .feat(dut_feat),
        .feat_col(dut_col), .line_done(dut_done), .line_feat_cnt(dut_lcnt)
`ifdef PAIR_DIFF_DIR_EN
        , .dir(dut_dir)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected outputs and line-level state
    int e_ov, e_diff, e_above, e_feat, e_col, e_done, e_lcnt, e_dir;
    bit m_active;
    int m_idx, m_run, m_cnt;
    bit m_rdir;

    int dut_feat_q[$];
    int dut_done_q[$];
    int mdl_feat_q[$];
    int mdl_done_q[$];
    int dut_ov_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input int q[$], input int i);
        if (i < q.size()) return q[i];
        else return -1;
    endfunction

    task automatic model_reset();
        e_ov = 0; e_diff = 0; e_above = 0; e_feat = 0; e_col = 0;
        e_done = 0; e_lcnt = 0; e_dir = 0;
        m_active = 0; m_idx = 0; m_run = 0; m_cnt = 0; m_rdir = 0;
    endtask

    task automatic report_line();
        e_done = 1;
        e_lcnt = (m_cnt > FCNT_MAX) ? FCNT_MAX : m_cnt;
        mdl_done_q.push_back(e_lcnt);
    endtask

    task automatic model_step();
        int  d;
        bit  closing;
        e_ov = 0; e_above = 0; e_feat = 0; e_col = 0; e_done = 0; e_dir = 0;
        closing = line_end && m_active;
        if (in_valid && line_start) begin
            if (closing) report_line();
            m_active = 1; m_idx = 1; m_run = 0; m_cnt = 0;
        end else begin
            if (in_valid && m_active) begin
                if (m_idx >= PRIME) begin
                    d = int'(p_near) - int'(p_far);
                    if (d < 0) d = -d;
                    e_ov    = 1;
                    e_diff  = d;
                    e_above = (d > int'(thresh)) ? 1 : 0;
                    e_dir   = (p_near > p_far) ? 1 : 0;
                    e_col   = (m_idx - PRIME > COL_MAX) ? COL_MAX : m_idx - PRIME;
                    if (e_above == 1) begin
                        if (DIR_ON && m_run > 0 && e_dir[0] != m_rdir) m_run = 1;
                        else m_run = m_run + 1;
                        m_rdir = e_dir[0];
                        if (m_run == MIN_RUN) begin
                            e_feat = 1;
                            m_cnt++;
                            mdl_feat_q.push_back(e_col);
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                m_idx++;
            end
            if (closing) begin
                report_line();
                m_active = 0;
            end
        end
    endtask

    // Compare process: advance the model on each active edge, check 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
            #1;
            check("out_valid", dut_ov, e_ov);
            check("diff", dut_diff, e_diff);
            check("above", dut_above, e_above);
            check("feat", dut_feat, e_feat);
            if (e_feat == 1) check("feat_col", dut_col, e_col);
            check("line_done", dut_done, e_done);
            check("line_feat_cnt", dut_lcnt, e_lcnt);
`ifdef PAIR_DIFF_DIR_EN
            if (e_ov == 1) check("dir", dut_dir, e_dir);
`endif
            if (dut_feat) dut_feat_q.push_back(int'(dut_col));
            if (dut_done) dut_done_q.push_back(int'(dut_lcnt));
            if (dut_ov) dut_ov_n++;
        end
    end

    task automatic send(input bit iv, input bit ls, input bit le, input int th, input int pf, input int pn);
        @(negedge clk);
        in_valid = iv; line_start = ls; line_end = le;
        thresh = DW'(th); p_far = DW'(pf); p_near = DW'(pn);
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 0, 0, 20, 0, 0);
    endtask

    task automatic start_line(input int th);
        send(1, 1, 0, th, 0, 0);
        repeat (PRIME - 1) send(1, 0, 0, th, 0, 0);
    endtask

    task automatic end_line();
        send(0, 0, 1, 20, 0, 0);
        idle(2);
    endtask

    task automatic clearq();
        dut_feat_q.delete(); dut_done_q.delete();
        mdl_feat_q.delete(); mdl_done_q.delete();
        dut_ov_n = 0;
    endtask

    int run_near[8] = '{130, 130, 130, 130, 110, 130, 130, 130};
    int bnd_near[5] = '{30, 30, 25, 30, 30};
    int dir_near[5] = '{130, 130, 70, 70, 70};

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Priming: 8 samples discarded, the remaining 4 processed with diff 150.
        clearq();
        send(1, 1, 0, 20, 200, 50);
        repeat (11) send(1, 0, 0, 20, 200, 50);
        end_line();
        check("prime_ov_n", dut_ov_n, 4);
        check("prime_feat_n", dut_feat_q.size(), 1);
        check("prime_feat_col", pick(dut_feat_q, 0), 2);
        check("prime_done_cnt", pick(dut_done_q, 0), 1);
        check("mdl_prime_done", pick(mdl_done_q, 0), 1);

        // Runs broken by one below-threshold sample: features at columns 2 and 7.
        clearq();
        start_line(20);
        foreach (run_near[i]) send(1, 0, 0, 20, 100, run_near[i]);
        end_line();
        check("run_feat_n", dut_feat_q.size(), 2);
        check("run_feat0", pick(dut_feat_q, 0), 2);
        check("run_feat1", pick(dut_feat_q, 1), 7);
        check("run_done_cnt", pick(dut_done_q, 0), 2);
        check("mdl_run_feat1", pick(mdl_feat_q, 1), 7);
        check("mdl_run_done", pick(mdl_done_q, 0), 2);

        // diff == thresh breaks the run; in_valid gaps do not.
        clearq();
        start_line(25);
        foreach (bnd_near[i]) send(1, 0, 0, 25, 0, bnd_near[i]);
        idle(2);
        send(1, 0, 0, 25, 0, 30);
        end_line();
        check("bnd_feat_n", dut_feat_q.size(), 1);
        check("bnd_feat_col", pick(dut_feat_q, 0), 5);
        check("mdl_bnd_feat", pick(mdl_feat_q, 0), 5);

        // Five features saturate a 2-bit count; close and reopen in one cycle.
        clearq();
        start_line(20);
        repeat (5) begin
            send(1, 0, 0, 20, 100, 130);
            send(1, 0, 0, 20, 100, 130);
            send(1, 0, 0, 20, 100, 130);
            send(1, 0, 0, 20, 100, 110);
        end
        send(1, 1, 1, 20, 0, 0);
        repeat (PRIME - 1) send(1, 0, 0, 20, 0, 0);
        repeat (3) send(1, 0, 0, 20, 100, 130);
        end_line();
        check("sat_feat_n", dut_feat_q.size(), 6);
        check("sat_done_n", dut_done_q.size(), 2);
        check("sat_done_old", pick(dut_done_q, 0), 3);
        check("sat_done_new", pick(dut_done_q, 1), 1);
        check("mdl_sat_done", pick(mdl_done_q, 0), 3);

        // Direction sequence +,+,-,-,- above threshold.
        clearq();
        start_line(20);
        foreach (dir_near[i]) send(1, 0, 0, 20, 100, dir_near[i]);
        end_line();
        check("dir_feat_n", dut_feat_q.size(), 1);
        check("dir_feat_col", pick(dut_feat_q, 0), DIR_FEAT_COL);
        check("mdl_dir_feat", pick(mdl_feat_q, 0), DIR_FEAT_COL);

        // Asynchronous reset in the middle of a line.
        start_line(20);
        send(1, 0, 0, 20, 100, 130);
        send(1, 0, 0, 20, 100, 130);
        @(posedge clk);
        #3;
        reset = 1'b1;
        in_valid = 1'b0; line_start = 1'b0; line_end = 1'b0;
        #1;
        check("rst_out_valid", dut_ov, 0);
        check("rst_diff", dut_diff, 0);
        check("rst_line_feat_cnt", dut_lcnt, 0);
        check("rst_above", dut_above, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearq();
        end_line();
        send(1, 0, 0, 20, 100, 130);
        idle(2);
        check("rst_no_done", dut_done_q.size(), 0);
        check("rst_idle_no_ov", dut_ov_n, 0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
